// File: rtl/pipe_shifter.sv
// pipe_shifter: fully pipelined barrel shifter (LSR/ASR/LSL/ROR), one register
// per power-of-two shift stage, valid/ready handshake with a combinational
// ready chain so bubbles collapse and a full pipe can accept while emitting.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   in_vld   operand valid            in_rdy  block can accept this cycle
//   src      operand                  amt     shift amount 0..WIDTH-1
//   op       00 LSR, 01 ASR, 10 LSL, 11 ROR
//   out_vld  res/zero valid           out_rdy consumer accepts this cycle
//   res      shifted result           zero    res == 0 (valid with out_vld)
module pipe_shifter #(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned AW    = $clog2(WIDTH),
  localparam int unsigned NSTG  = AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] src,
  input  logic [AW-1:0]    amt,
  input  logic [1:0]       op,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] res,
  output logic             zero
);

  localparam logic [1:0] OP_LSR = 2'b00;
  localparam logic [1:0] OP_ASR = 2'b01;
  localparam logic [1:0] OP_LSL = 2'b10;

  // One fixed-distance shift step; sgn is the original operand MSB.
  function automatic logic [WIDTH-1:0] f_stage(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       o,
    input logic             sgn,
    input int unsigned      sh
  );
    logic [WIDTH-1:0] v_fill;
    logic [WIDTH-1:0] v_res;
    v_fill = ~({WIDTH{1'b1}} >> sh);
    case (o)
      OP_LSR:  v_res = d >> sh;
      OP_ASR:  v_res = (d >> sh) | (sgn ? v_fill : '0);
      OP_LSL:  v_res = d << sh;
      default: v_res = (d >> sh) | (d << (WIDTH - sh));
    endcase
    return v_res;
  endfunction

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic             r_vld;
    logic [WIDTH-1:0] r_data;
    logic [AW-1:0]    r_amt;
    logic [1:0]       r_op;
    logic             r_sign;

    logic             w_vin;
    logic [WIDTH-1:0] w_din;
    logic [AW-1:0]    w_ain;
    logic [1:0]       w_oin;
    logic             w_sin;
    logic [WIDTH-1:0] w_dout;
    logic             w_adv;

    // Stage inputs: operand ports for stage 0, previous register otherwise.
    if (k == 0) begin : g_src
      assign w_vin = in_vld;
      assign w_din = src;
      assign w_ain = amt;
      assign w_oin = op;
      assign w_sin = src[WIDTH-1];
    end else begin : g_chain
      assign w_vin = g_stg[k-1].r_vld;
      assign w_din = g_stg[k-1].r_data;
      assign w_ain = g_stg[k-1].r_amt;
      assign w_oin = g_stg[k-1].r_op;
      assign w_sin = g_stg[k-1].r_sign;
    end

    // A slot may load when empty or when its content moves on this cycle.
    if (k == NSTG - 1) begin : g_last
      assign w_adv = !r_vld || out_rdy;
    end else begin : g_mid
      assign w_adv = !r_vld || g_stg[k+1].w_adv;
    end

    assign w_dout = w_ain[k] ? f_stage(w_din, w_oin, w_sin, 32'(1) << k) : w_din;

    // Payload only loads with a valid item, so a bubble leaves data untouched.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_vld  <= 1'b0;
        r_data <= '0;
        r_amt  <= '0;
        r_op   <= '0;
        r_sign <= 1'b0;
      end else if (w_adv) begin
        r_vld <= w_vin;
        if (w_vin) begin
          r_data <= w_dout;
          r_amt  <= w_ain;
          r_op   <= w_oin;
          r_sign <= w_sin;
        end
      end
    end
  end

  logic r_zero;

  // Zero flag travels with the final-stage data register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
    end else if (g_stg[NSTG-1].w_adv && g_stg[NSTG-1].w_vin) begin
      r_zero <= (g_stg[NSTG-1].w_dout == '0);
    end
  end

  // Final-stage shift metadata has no consumer.
  logic w_unused_meta;
  assign w_unused_meta = ^{g_stg[NSTG-1].r_amt, g_stg[NSTG-1].r_op, g_stg[NSTG-1].r_sign};

  assign in_rdy  = g_stg[0].w_adv;
  assign out_vld = g_stg[NSTG-1].r_vld;
  assign res     = g_stg[NSTG-1].r_data;
  assign zero    = r_zero;

endmodule

// File: tb/tb_pipe_shifter.sv
module tb_pipe_shifter;

  logic        clk;
  logic        rst_n;

  logic        in_vld, in_rdy, out_vld, out_rdy, zero;
  logic [15:0] src, res;
  logic [3:0]  amt;
  logic [1:0]  op;

  logic        d_in_vld, d_in_rdy, d_out_vld, d_out_rdy, d_zero;
  logic [31:0] d_src, d_res;
  logic [4:0]  d_amt;
  logic [1:0]  d_op;

  pipe_shifter #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .src(src),
    .amt(amt), .op(op), .out_vld(out_vld), .out_rdy(out_rdy), .res(res), .zero(zero)
  );

  pipe_shifter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_vld(d_in_vld), .in_rdy(d_in_rdy), .src(d_src),
    .amt(d_amt), .op(d_op), .out_vld(d_out_vld), .out_rdy(d_out_rdy), .res(d_res), .zero(d_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] src;
    logic [3:0]  amt;
    logic [1:0]  op;
    logic [15:0] res;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    int          t;
  } exp_t;

  exp_t        q[$];
  int          n_chk, n_pass, n_acc, n_emit, cyc;
  logic        s_in_rdy, s_out_vld, last_acc;
  logic [15:0] s_res;
  logic [15:0] bs[8];
  vec_t        tv[10];

  // Reference: shift rules applied with plain wide arithmetic.
  function automatic logic [63:0] ref_shift(input logic [63:0] s, input int a,
                                            input logic [1:0] o, input int w);
    logic [63:0]        m;
    logic [63:0]        r;
    logic signed [63:0] sx;
    m = (64'd1 << w) - 64'd1;
    s = s & m;
    case (o)
      2'b00: r = s >> a;
      2'b01: begin
        sx = $signed(s);
        if (s[w-1]) sx = sx | $signed(~m);
        r = 64'(sx >>> a) & m;
      end
      2'b10: r = (s << a) & m;
      default: r = ((s >> a) | (s << (w - a))) & m;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
  endtask

  // One clock: drive, sample mid-cycle, score handshakes, advance.
  task automatic tick(input logic v, input logic [15:0] s, input logic [3:0] a,
                      input logic [1:0] o, input logic ordy, input bit lat,
                      input logic [15:0] e);
    exp_t x;
    in_vld = v; src = s; amt = a; op = o; out_rdy = ordy;
    #3;
    s_in_rdy  = in_rdy;
    s_out_vld = out_vld;
    s_res     = res;
    last_acc  = in_vld && in_rdy;
    if (out_vld && out_rdy) begin
      n_emit++;
      if (q.size() == 0) begin
        chk("spurious_out", 64'(1), 64'(0));
      end else begin
        x = q.pop_front();
        chk("res", 64'(res), 64'(x.res));
        chk("zero", 64'(zero), 64'(x.res == 16'h0));
        if (lat) chk("latency", 64'(cyc - x.t), 64'(4));
      end
    end
    if (last_acc) begin
      x.res = e;
      x.t   = cyc;
      q.push_back(x);
      n_acc++;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain(input bit lat);
    for (int i = 0; i < 64 && q.size() > 0; i++) tick(1'b0, '0, '0, '0, 1'b1, lat, '0);
    chk("drain_empty", 64'(q.size()), 64'(0));
  endtask

  function automatic logic [15:0] bp_exp(input int i);
    return 16'(ref_shift(64'(bs[i]), (i * 3) % 16, 2'(i), 16));
  endfunction

  logic [31:0] w32_src[4];
  logic [4:0]  w32_amt[4];
  logic [1:0]  w32_op[4];
  logic [31:0] w32_res[4];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, e0, idx, lat;
    logic [15:0] rs;
    logic [3:0]  ra;
    logic [1:0]  ro;

    n_chk = 0; n_pass = 0; n_acc = 0; n_emit = 0; cyc = 0;
    rst_n = 1'b0;
    in_vld = 0; src = '0; amt = '0; op = '0; out_rdy = 0;
    d_in_vld = 0; d_src = '0; d_amt = '0; d_op = '0; d_out_rdy = 0;

    tv[0] = '{16'h8000, 4'd15, 2'b01, 16'hFFFF};
    tv[1] = '{16'h8000, 4'd15, 2'b00, 16'h0001};
    tv[2] = '{16'h0001, 4'd15, 2'b10, 16'h8000};
    tv[3] = '{16'h0001, 4'd1,  2'b11, 16'h8000};
    tv[4] = '{16'hA5C3, 4'd0,  2'b00, 16'hA5C3};
    tv[5] = '{16'hA5C3, 4'd0,  2'b01, 16'hA5C3};
    tv[6] = '{16'hA5C3, 4'd0,  2'b10, 16'hA5C3};
    tv[7] = '{16'hA5C3, 4'd0,  2'b11, 16'hA5C3};
    tv[8] = '{16'h00F0, 4'd4,  2'b00, 16'h000F};
    tv[9] = '{16'h000F, 4'd4,  2'b00, 16'h0000};

    for (int i = 0; i < 8; i++) bs[i] = 16'((i + 1) * 16'h1357);

    w32_src[0] = 32'h8000_0000; w32_amt[0] = 5'd31; w32_op[0] = 2'b01; w32_res[0] = 32'hFFFF_FFFF;
    w32_src[1] = 32'h8000_0000; w32_amt[1] = 5'd31; w32_op[1] = 2'b00; w32_res[1] = 32'h0000_0001;
    w32_src[2] = 32'h0000_0001; w32_amt[2] = 5'd31; w32_op[2] = 2'b10; w32_res[2] = 32'h8000_0000;
    w32_src[3] = 32'h0000_0001; w32_amt[3] = 5'd1;  w32_op[3] = 2'b11; w32_res[3] = 32'h8000_0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    #3;
    chk("rst_out_vld", 64'(out_vld), 64'(0));
    chk("rst_res", 64'(res), 64'(0));
    chk("rst_zero", 64'(zero), 64'(0));
    chk("rst_in_rdy", 64'(in_rdy), 64'(1));
    @(posedge clk); #1;

    // Directed vectors, back-to-back with out_rdy high
    for (int i = 0; i < 10; i++)
      tick(1'b1, tv[i].src, tv[i].amt, tv[i].op, 1'b1, 1'b1, tv[i].res);
    drain(1'b1);

    // Backpressure: pipe holds exactly four items and a stable head
    a0 = n_acc; idx = 0;
    for (int c = 0; c < 10; c++) begin
      tick(1'b1, bs[idx], 4'((idx * 3) % 16), 2'(idx), 1'b0, 1'b0, bp_exp(idx));
      if (last_acc) idx++;
      if (c == 5) chk("bp_res_head_early", 64'(s_res), 64'(bp_exp(0)));
    end
    chk("bp_accepted", 64'(n_acc - a0), 64'(4));
    chk("bp_in_rdy", 64'(s_in_rdy), 64'(0));
    chk("bp_out_vld", 64'(s_out_vld), 64'(1));
    chk("bp_res_head_late", 64'(s_res), 64'(bp_exp(0)));
    e0 = n_emit;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      tick(1'b1, bs[idx], 4'((idx * 3) % 16), 2'(idx), 1'b1, 1'b0, bp_exp(idx));
      if (last_acc) idx++;
    end
    drain(1'b0);
    chk("bp_emitted", 64'(n_emit - e0), 64'(8));

    // Random traffic against the reference model
    a0 = n_acc;
    for (int c = 0; c < 20000 && (n_acc - a0) < 1000; c++) begin
      rs = 16'($urandom);
      ra = 4'($urandom);
      ro = 2'($urandom);
      tick(1'($urandom_range(0, 1)), rs, ra, ro, 1'($urandom_range(0, 1)), 1'b0,
           16'(ref_shift(64'(rs), int'(ra), ro, 16)));
    end
    chk("rand_accepted", 64'(n_acc - a0), 64'(1000));
    drain(1'b0);

    // Reset with three items in flight
    for (int i = 0; i < 3; i++)
      tick(1'b1, bs[i], 4'((i * 3) % 16), 2'(i), 1'b0, 1'b0, bp_exp(i));
    rst_n = 1'b0;
    tick(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    rst_n = 1'b1;
    q.delete();
    in_vld = 1'b0; out_rdy = 1'b0;
    #3;
    chk("mid_rst_out_vld", 64'(out_vld), 64'(0));
    chk("mid_rst_res", 64'(res), 64'(0));
    chk("mid_rst_zero", 64'(zero), 64'(0));
    chk("mid_rst_in_rdy", 64'(in_rdy), 64'(1));
    @(posedge clk); #1;
    for (int c = 0; c < 8; c++) begin
      tick(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
      chk("no_stale", 64'(s_out_vld), 64'(0));
    end

    // 32-bit instance: latency five
    for (int i = 0; i < 4; i++) begin
      d_in_vld = 1'b1; d_src = w32_src[i]; d_amt = w32_amt[i]; d_op = w32_op[i]; d_out_rdy = 1'b1;
      #3;
      chk("w32_in_rdy", 64'(d_in_rdy), 64'(1));
      @(posedge clk); #1;
      d_in_vld = 1'b0;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
        #3;
        if (d_out_vld) begin
          lat = n;
          break;
        end
        @(posedge clk); #1;
      end
      chk("w32_latency", 64'(lat), 64'(5));
      chk("w32_res", 64'(d_res), 64'(w32_res[i]));
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_shifter.md
Name: pipe_shifter

Overview:
Parametrised, fully pipelined barrel shifter. It is the next generation of the single-cycle 16-bit right shifter. It adds logical left shift and rotate right, configurable width, and one register per shift stage. A valid/ready handshake with backpressure lets it sit between any producer and consumer in the ALU datapath.

Parameters:
WIDTH, 16, data width in bits; power of two, 4 to 64.
AW, $clog2(WIDTH), shift-amount width; derived, not overridden.
NSTG, AW, number of pipeline stages; derived. Latency equals NSTG.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_vld  in  1  input operand valid
in_rdy  out  1  block can accept an operand this cycle
src  in  WIDTH  operand to shift
amt  in  AW  shift amount, 0..WIDTH-1
op  in  2  00 LSR, 01 ASR, 10 LSL, 11 ROR
out_vld  out  1  res/zero valid
out_rdy  in  1  consumer accepts result this cycle
res  out  WIDTH  shifted result
zero  out  1  res == 0

Behaviour:
- Reset: rst_n sampled low at a rising edge clears every stage's valid bit, data, amt and op registers to 0.
  - After reset: out_vld=0, res=0, zero=0.
  - in_rdy is 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight items; nothing is emitted for them.
- Stage k (k = 0..NSTG-1) shifts by 2^k when amt[k]=1, otherwise passes its data through.
  - Stage k registers data, the remaining amt bits, op, and a valid bit.
  - Stage NSTG-1's register drives res/out_vld. res comes straight from that register (no combinational path from src).
- Fill rules per stage:
  - LSR: zeros shift into the MSBs.
  - ASR: the original bit WIDTH-1 (the sign bit, carried unchanged through all stages) fills the MSBs.
  - LSL: zeros shift into the LSBs.
  - ROR: bits shifted out of the LSB re-enter at the MSB. ROR by 0 is identity.
- zero is computed from the final-stage data and registered alongside it; it is valid only when out_vld=1.
- Handshake:
  - Input is accepted on an edge where in_vld && in_rdy.
  - Output is consumed on an edge where out_vld && out_rdy.
  - Stage k advances when its downstream slot is empty or is itself advancing (adv_k = !vld_{k+1} || adv_{k+1}; adv_last = !out_vld || out_rdy).
  - in_rdy = adv_0. The ready chain is combinational. Bubbles collapse.
  - A stalled stage holds its data, amt, op and valid unchanged.
- Latency and capacity:
  - Latency is NSTG cycles from acceptance to out_vld with out_rdy held high.
  - Throughput is 1 per cycle.
  - Capacity is NSTG items. With out_rdy low, exactly NSTG items are accepted, then in_rdy=0.
- Ordering: results leave strictly in acceptance order; none are dropped or duplicated.
- Simultaneous accept and emit on a full pipe is legal (out_rdy=1 makes in_rdy=1), and occupancy stays at NSTG.
- in_vld=0 inserts a bubble. src/amt/op are don't-care when in_vld=0.
- out_vld and res must not change while out_vld=1 && out_rdy=0.

Test Plan:
- WIDTH=16, out_rdy=1, back-to-back:
  - (0x8000, 15, ASR) -> 0xFFFF
  - (0x8000, 15, LSR) -> 0x0001
  - (0x0001, 15, LSL) -> 0x8000
  - (0x0001, 1, ROR) -> 0x8000
  - Each appears 4 cycles after acceptance, on consecutive cycles.
- amt=0, all four ops, src=0xA5C3 -> res=0xA5C3 each. (0x00F0, 4, LSR) -> res=0x000F, zero=0. (0x000F, 4, LSR) -> res=0x0000, zero=1.
- Backpressure:
  - Hold out_rdy=0 and drive in_vld=1 with 8 distinct operands: exactly 4 are accepted, then in_rdy=0 and res is held stable.
  - Raise out_rdy: all 8 results emerge in order, with no loss.
- Random in_vld/out_rdy toggling (~50%) with 1000 random operands and ops, checked against a reference model via scoreboard: every result matches, in order.
- Assert rst_n=0 for 1 cycle with 3 items in flight -> out_vld=0 and res=0 next cycle, and no stale results follow. in_rdy=1 in the first cycle after reset.
- Rerun the first scenario at WIDTH=32: (0x80000000, 31, ASR) -> 0xFFFFFFFF with latency 5.
